em_access_unit: RTL and testbench

//  Initiator side of the external-memory data port. Accepts one CPU load/store per handshake.

---
 rtl/em_access_unit.sv | 193 +++++++++++++++++++
 tb/tb_em_access_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/em_access_unit.sv
// Initiator side of the external-memory data port: one CPU load/store per handshake.
// Build option EMAU_ALIGN_CHECK_EN adds misaligned halfword/word faults.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | req_ready high, waiting for a request; lanes hold last value
//   ST_ACCESS | lanes driven, control pulses for a legal store, Read sampled
//   ST_RESP   | one-cycle resp_valid with result or fault

module em_access_unit #(
  parameter int MEM_SIZE = 125
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [2:0]  control,
  output logic [39:0] Address,
  output logic [7:0]  DW0,
  output logic [7:0]  DW1,
  output logic [7:0]  DW2,
  output logic [7:0]  DW3,
  input  logic [31:0] Read
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [10:0] MEM_LIMIT = 11'(MEM_SIZE);

  state_t          state_q, state_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_rdata_q, resp_rdata_d;
  logic            resp_fault_q, resp_fault_d;
  logic [2:0]      control_q, control_d;
  logic [3:0][9:0] address_q, address_d;
  logic [3:0][7:0] dw_q, dw_d;
  logic            wr_q, wr_d;
  logic [1:0]      size_q, size_d;
  logic            signed_q, signed_d;
  logic            fault_q, fault_d;

  logic [3:0]      lane_used;
  logic [1:0]      lane_span;
  logic [10:0]     last_lane;
  logic            misaligned;
  logic            req_fault;
  logic [31:0]     load_ext;

  // Fault decision on the incoming request, evaluated at capture time.
  always_comb begin
    lane_used = 4'b1111;
    lane_span = 2'd3;
    case (req_size)
      2'd0: begin
        lane_used = 4'b0001;
        lane_span = 2'd0;
      end
      2'd1: begin
        lane_used = 4'b0011;
        lane_span = 2'd1;
      end
      default: ;
    endcase
    last_lane = {1'b0, req_addr} + {9'd0, lane_span};
`ifdef EMAU_ALIGN_CHECK_EN
    misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                 ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    req_fault = (req_size == 2'd3) || last_lane[10] || (last_lane >= MEM_LIMIT) || misaligned;
  end

  always_comb begin
    case (size_q)
      2'd0:    load_ext = {{24{signed_q & Read[7]}}, Read[7:0]};
      2'd1:    load_ext = {{16{signed_q & Read[15]}}, Read[15:0]};
      default: load_ext = Read;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_fault_d = 1'b0;
    control_d    = 3'd0;
    address_d    = address_q;
    dw_d         = dw_q;
    wr_d         = wr_q;
    size_d       = size_q;
    signed_d     = signed_q;
    fault_d      = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d     = ST_ACCESS;
          req_ready_d = 1'b0;
          wr_d        = req_write;
          size_d      = req_size;
          signed_d    = req_signed;
          fault_d     = req_fault;
          // Unused lanes repeat lane 0 so the memory's all-lanes-valid read gate stays open.
          for (int k = 0; k < 4; k++) begin
            if (lane_used[k]) begin
              address_d[k] = req_addr + 10'(k);
              dw_d[k]      = req_wdata[8*k +: 8];
            end else begin
              address_d[k] = req_addr;
              dw_d[k]      = req_wdata[7:0];
            end
          end
          if (req_write && !req_fault) begin
            control_d = {1'b0, req_size} + 3'd1;
          end
        end
      end
      ST_ACCESS: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_fault_d = fault_q;
        if (!wr_q && !fault_q) begin
          resp_rdata_d = load_ext;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_fault_q <= 1'b0;
      control_q    <= 3'd0;
      address_q    <= '0;
      dw_q         <= '0;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      control_q    <= control_d;
      address_q    <= address_d;
      dw_q         <= dw_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      fault_q      <= fault_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;
  assign control    = control_q;
  assign Address    = address_q;
  assign DW0        = dw_q[0];
  assign DW1        = dw_q[1];
  assign DW2        = dw_q[2];
  assign DW3        = dw_q[3];

endmodule

// File: tb/tb_em_access_unit.sv
// Bench for em_access_unit: a byte-array memory on the port plus a request-level reference model.
// Honours EMAU_ALIGN_CHECK_EN the same way the design does.

module tb_em_access_unit;

  localparam int MEM_SIZE = 125;
  localparam logic [9:0] MEM_LIM = 10'(MEM_SIZE);

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [2:0]  control;
  logic [39:0] Address;
  logic [7:0]  DW0, DW1, DW2, DW3;
  logic [31:0] Read;
  logic [31:0] dw_bus;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem      [0:1023];
  logic [7:0] seed_mem [0:1023];
  logic [7:0] ref_mem  [0:1023];
  logic       mem_load;

  typedef struct {
    logic        timeout;
    logic [2:0]  ctl;
    logic [39:0] addr_bus;
    logic [31:0] dw;
    logic        rv_access;
    logic        rdy_access;
    logic        rv;
    logic [31:0] rdata;
    logic        fault;
    logic        rdy_resp;
    logic [2:0]  ctl_resp;
  } obs_t;

  always #5 clock = ~clock;

  em_access_unit #(.MEM_SIZE(MEM_SIZE)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .control(control), .Address(Address),
    .DW0(DW0), .DW1(DW1), .DW2(DW2), .DW3(DW3), .Read(Read)
  );

  assign dw_bus = {DW3, DW2, DW1, DW0};

  // External memory: combinational read gated on all lanes in range; writes share the reset.
  assign Read = ((Address[9:0] >= MEM_LIM) || (Address[19:10] >= MEM_LIM) ||
                 (Address[29:20] >= MEM_LIM) || (Address[39:30] >= MEM_LIM)) ? 32'd0 :
                {mem[Address[39:30]], mem[Address[29:20]], mem[Address[19:10]], mem[Address[9:0]]};

  always @(posedge clock) begin
    if (mem_load) begin
      for (int i = 0; i < 1024; i++) mem[i] <= seed_mem[i];
    end else if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        if (((k == 0) && (control != 3'd0)) || ((k == 1) && (control >= 3'd2)) ||
            ((k >= 2) && (control == 3'd3))) begin
          if (Address[k*10 +: 10] < MEM_LIM) mem[Address[k*10 +: 10]] <= dw_bus[k*8 +: 8];
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic exp_fault(input int sz, input int a);
    int n;
    if (sz == 3) return 1'b1;
    n = 1 << sz;
    if (a + n > MEM_SIZE) return 1'b1;
`ifdef EMAU_ALIGN_CHECK_EN
    if ((a % n) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(input int sz, input logic sg, input int a);
    longint v;
    int n;
    n = 1 << sz;
    v = 0;
    for (int k = 0; k < n; k++) v = v + (longint'(ref_mem[a + k]) << (8 * k));
    if (sg && (n < 4) && (v >= (longint'(1) << (8 * n - 1)))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [39:0] exp_addr(input int sz, input int a);
    logic [39:0] r;
    int n;
    int lane;
    n = 1 << sz;
    for (int k = 0; k < 4; k++) begin
      lane = (k < n) ? ((a + k) % 1024) : a;
      r[k*10 +: 10] = 10'(lane);
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_dw(input int sz, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = 1 << sz;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = (k < n) ? wd[k*8 +: 8] : wd[7:0];
    return r;
  endfunction

  task automatic ref_store(input int sz, input int a, input logic [31:0] wd);
    for (int k = 0; k < (1 << sz); k++) ref_mem[a + k] = wd[k*8 +: 8];
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [9:0] a,
                       input logic [31:0] wd, output obs_t o);
    int cyc;
    o = '{default: '0};
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    cyc = 0;
    while ((req_ready !== 1'b1) && (cyc < 20)) begin
      @(negedge clock);
      cyc++;
    end
    if (cyc >= 20) begin
      errors++;
      $display("FAIL issue_timeout: req_ready stayed %b, required 1", req_ready);
      o.timeout = 1'b1;
      req_valid = 1'b0;
      return;
    end
    @(negedge clock);
    req_valid    = 1'b0;
    o.ctl        = control;
    o.addr_bus   = Address;
    o.dw         = dw_bus;
    o.rv_access  = resp_valid;
    o.rdy_access = req_ready;
    @(negedge clock);
    o.rv       = resp_valid;
    o.rdata    = resp_rdata;
    o.fault    = resp_fault;
    o.rdy_resp = req_ready;
    o.ctl_resp = control;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    mem_load = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b need 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b need 0", resp_valid); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h need 0", resp_rdata); end
    checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b need 0", resp_fault); end
    checks++; if (control !== 3'd0) begin errors++; $display("FAIL reset_control: got %0d need 0", control); end
    checks++; if (Address !== 40'd0) begin errors++; $display("FAIL reset_address: got %h need 0", Address); end
    checks++; if (dw_bus !== 32'd0) begin errors++; $display("FAIL reset_dw: got %h need 0", dw_bus); end
  endtask

  task automatic test_directed();
    obs_t o;
    issue(1'b1, 2'd2, 1'b0, 10'd40, 32'h11223344, o);
    ref_store(2, 40, 32'h11223344);
    checks++; if (o.ctl !== 3'd3) begin errors++; $display("FAIL sw40_control: got %0d need 3", o.ctl); end
    checks++; if (o.addr_bus !== {10'd43, 10'd42, 10'd41, 10'd40}) begin errors++; $display("FAIL sw40_address: got %h need %h", o.addr_bus, {10'd43, 10'd42, 10'd41, 10'd40}); end
    checks++; if (o.dw !== 32'h11223344) begin errors++; $display("FAIL sw40_dw: got %h need 11223344", o.dw); end
    checks++; if (o.rv !== 1'b1 || o.fault !== 1'b0) begin errors++; $display("FAIL sw40_resp: got valid %b fault %b need 1 0", o.rv, o.fault); end
    issue(1'b0, 2'd2, 1'b0, 10'd40, 32'd0, o);
    checks++; if (o.rdata !== 32'h11223344 || o.fault !== 1'b0) begin errors++; $display("FAIL lw40: got %h fault %b need 11223344 0", o.rdata, o.fault); end

    issue(1'b1, 2'd0, 1'b0, 10'd50, 32'h000000F0, o);
    ref_store(0, 50, 32'h000000F0);
    checks++; if (o.ctl !== 3'd1) begin errors++; $display("FAIL sb50_control: got %0d need 1", o.ctl); end
    checks++; if (o.addr_bus !== {4{10'd50}}) begin errors++; $display("FAIL sb50_address: got %h need %h", o.addr_bus, {4{10'd50}}); end
    issue(1'b0, 2'd0, 1'b1, 10'd50, 32'd0, o);
    checks++; if (o.rdata !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb50_signed: got %h need FFFFFFF0", o.rdata); end
    issue(1'b0, 2'd0, 1'b0, 10'd50, 32'd0, o);
    checks++; if (o.rdata !== 32'h000000F0) begin errors++; $display("FAIL lb50_unsigned: got %h need 000000F0", o.rdata); end

    issue(1'b0, 2'd0, 1'b0, 10'd124, 32'd0, o);
    checks++; if (o.addr_bus !== {4{10'd124}} || o.fault !== 1'b0) begin errors++; $display("FAIL lb124: got addr %h fault %b need %h 0", o.addr_bus, o.fault, {4{10'd124}}); end
    checks++; if (o.rdata !== exp_load(0, 1'b0, 124)) begin errors++; $display("FAIL lb124_data: got %h need %h", o.rdata, exp_load(0, 1'b0, 124)); end
    issue(1'b0, 2'd2, 1'b0, 10'd123, 32'd0, o);
    checks++; if (o.fault !== 1'b1 || o.rdata !== 32'd0 || o.ctl !== 3'd0) begin errors++; $display("FAIL lw123: got fault %b data %h ctl %0d need 1 0 0", o.fault, o.rdata, o.ctl); end
    issue(1'b1, 2'd3, 1'b0, 10'd0, 32'hDEADBEEF, o);
    checks++; if (o.fault !== 1'b1 || o.ctl !== 3'd0) begin errors++; $display("FAIL size3: got fault %b ctl %0d need 1 0", o.fault, o.ctl); end

    issue(1'b0, 2'd1, 1'b0, 10'd41, 32'd0, o);
`ifdef EMAU_ALIGN_CHECK_EN
    checks++; if (o.fault !== 1'b1 || o.rdata !== 32'd0) begin errors++; $display("FAIL lh41: got fault %b data %h need 1 0", o.fault, o.rdata); end
`else
    checks++; if (o.fault !== 1'b0 || o.rdata !== 32'h00002233) begin errors++; $display("FAIL lh41: got fault %b data %h need 0 00002233", o.fault, o.rdata); end
`endif
  endtask

  task automatic test_random();
    obs_t o;
    logic w, sg, ef;
    logic [1:0] sz;
    logic [9:0] a;
    logic [31:0] wd, er;
    logic [2:0] ectl;
    int r;
    for (int i = 0; i < 200; i++) begin
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a  = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1018, 1023)) : 10'($urandom_range(0, MEM_SIZE + 3));
      wd = $urandom;
      ef = exp_fault(int'(sz), int'(a));
      er = (w || ef) ? 32'd0 : exp_load(int'(sz), sg, int'(a));
      ectl = (w && !ef) ? 3'(sz) + 3'd1 : 3'd0;
      issue(w, sz, sg, a, wd, o);
      checks++; if (o.rv_access !== 1'b0 || o.rdy_access !== 1'b0) begin errors++; $display("FAIL rnd_access_flags #%0d: got valid %b ready %b need 0 0", i, o.rv_access, o.rdy_access); end
      checks++; if (o.ctl !== ectl) begin errors++; $display("FAIL rnd_control #%0d: got %0d need %0d", i, o.ctl, ectl); end
      checks++; if (o.rv !== 1'b1 || o.rdy_resp !== 1'b0 || o.ctl_resp !== 3'd0) begin errors++; $display("FAIL rnd_resp_flags #%0d: got valid %b ready %b ctl %0d need 1 0 0", i, o.rv, o.rdy_resp, o.ctl_resp); end
      checks++; if (o.fault !== ef) begin errors++; $display("FAIL rnd_fault #%0d: got %b need %b (size %0d addr %0d)", i, o.fault, ef, sz, a); end
      checks++; if (o.rdata !== er) begin errors++; $display("FAIL rnd_rdata #%0d: got %h need %h (size %0d addr %0d signed %b)", i, o.rdata, er, sz, a, sg); end
      if (sz != 2'd3) begin
        checks++; if (o.addr_bus !== exp_addr(int'(sz), int'(a))) begin errors++; $display("FAIL rnd_address #%0d: got %h need %h", i, o.addr_bus, exp_addr(int'(sz), int'(a))); end
        checks++; if (o.dw !== exp_dw(int'(sz), wd)) begin errors++; $display("FAIL rnd_dw #%0d: got %h need %h", i, o.dw, exp_dw(int'(sz), wd)); end
      end
      if (w && !ef) ref_store(int'(sz), int'(a), wd);
    end
  endtask

  task automatic test_back_to_back();
    int accepted;
    logic [31:0] er;
    @(negedge clock);
    er = exp_load(2, 1'b0, 8);
    accepted = 0;
    req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 10'd8; req_wdata = 32'd0;
    req_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (req_ready === 1'b1) accepted++;
      checks++; if (req_ready !== ((i % 3) == 0)) begin errors++; $display("FAIL b2b_ready cycle %0d: got %b need %b", i, req_ready, (i % 3) == 0); end
      checks++; if (resp_valid !== ((i % 3) == 2)) begin errors++; $display("FAIL b2b_resp_valid cycle %0d: got %b need %b", i, resp_valid, (i % 3) == 2); end
      if ((i % 3) == 2) begin
        checks++; if (resp_rdata !== er) begin errors++; $display("FAIL b2b_rdata cycle %0d: got %h need %h", i, resp_rdata, er); end
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    checks++; if (accepted !== 3) begin errors++; $display("FAIL b2b_accept_count: got %0d need 3", accepted); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int cyc;
    logic seen_valid;
    logic [31:0] er;
    er = exp_load(2, 1'b0, 60);
    @(negedge clock);
    req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_addr = 10'd60; req_wdata = 32'hA55A_C33C;
    req_valid = 1'b1;
    cyc = 0;
    while ((req_ready !== 1'b1) && (cyc < 20)) begin
      @(negedge clock);
      cyc++;
    end
    if (cyc >= 20) begin
      errors++;
      $display("FAIL rstmid_timeout: req_ready stayed %b, required 1", req_ready);
    end
    @(negedge clock);
    req_valid = 1'b0;
    checks++; if (control !== 3'd3) begin errors++; $display("FAIL rstmid_access_control: got %0d need 3", control); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (req_ready !== 1'b1 || control !== 3'd0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after: got ready %b ctl %0d valid %b need 1 0 0", req_ready, control, resp_valid); end
    checks++; if (Address !== 40'd0) begin errors++; $display("FAIL rstmid_address: got %h need 0", Address); end
    seen_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (resp_valid === 1'b1) seen_valid = 1'b1;
    end
    checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_resp: got resp_valid pulse %b need 0", seen_valid); end
    issue(1'b0, 2'd2, 1'b0, 10'd60, 32'd0, o);
    checks++; if (o.rdata !== er || o.fault !== 1'b0) begin errors++; $display("FAIL rstmid_mem_kept: got %h fault %b need %h 0", o.rdata, o.fault, er); end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 10'd0; req_wdata = 32'd0;
    for (int i = 0; i < 1024; i++) begin
      seed_mem[i] = 8'($urandom);
      ref_mem[i]  = seed_mem[i];
    end
    mem_load = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time exceeded, required completion");
    $fatal(1, "global timeout");
  end

endmodule
